seg7_scan_driver: RTL and testbench

Output-side user-interface block: the board-facing counterpart of the input debouncer. It takes the player's status (song number, speed, play state) as eight hex nibbles plus blank/blink masks, and drives a time-multiplexed 8-digit common-anode-buffered 7-segment display. Loads go into a shadow register and commit only at a frame boundary, so a display frame never mixes old and new data.

---
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Load/status/display bundle for seg7_scan_driver; master loads, slave drives the panel.
// Loads are single-cycle strobes with no backpressure; pending reports uncommitted data.
interface seg7_scan_driver_if;
    logic        load;
    logic [31:0] load_data;
    logic [7:0]  load_blank;
    logic [7:0]  load_blink;
    logic        pending;
    logic [7:0]  seg_out;
    logic [7:0]  digit_en;

    modport master (
        output load, load_data, load_blank, load_blink,
        input  pending, seg_out, digit_en
    );

    modport slave (
        input  load, load_data, load_blank, load_blink,
        output pending, seg_out, digit_en
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed 7-segment driver; shadow loads commit only at frame boundaries.
// seg_out/digit_en are registered one cycle behind the scan index; loads are never stalled.
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_driver_if.slave bus
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          scan_end;
    logic          frame_end;

    logic [31:0]   shadow_data;
    logic [7:0]    shadow_blank;
    logic [7:0]    shadow_blink;
    logic          pending;

    logic [31:0]   disp_data;
    logic [7:0]    disp_blank;
    logic [7:0]    disp_blink;

    logic [3:0]    cur_nib;
    logic          cur_dark;
    logic [7:0]    seg_nxt;
    logic [7:0]    en_nxt;
    logic [7:0]    seg_q;
    logic [7:0]    en_q;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign scan_end  = (scan_cnt == SCAN_LAST);
    assign frame_end = scan_end && (idx == 3'd7);

    // Scan timing: digit slot counter, digit index, and blink frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            scan_cnt <= scan_end ? '0 : scan_cnt + 1'b1;
            if (scan_end)
                idx <= idx + 3'd1;
            if (frame_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load coinciding with a boundary wins pending; the commit still takes the old shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_data  <= 32'h0;
            shadow_blank <= 8'hFF;
            shadow_blink <= 8'h00;
            pending      <= 1'b0;
            disp_data    <= 32'h0;
            disp_blank   <= 8'hFF;
            disp_blink   <= 8'h00;
        end else begin
            if (frame_end && pending) begin
                disp_data  <= shadow_data;
                disp_blank <= shadow_blank;
                disp_blink <= shadow_blink;
            end
            if (bus.load) begin
                shadow_data  <= bus.load_data;
                shadow_blank <= bus.load_blank;
                shadow_blink <= bus.load_blink;
                pending      <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib  = disp_data[{idx, 2'b00} +: 4];
        cur_dark = disp_blank[idx] | (disp_blink[idx] & blink_phase);
        seg_nxt  = cur_dark ? 8'h00 : {1'b0, hex7(cur_nib)};
        en_nxt   = 8'h01 << idx;
    end

    // Dark digits keep their select so every slot lasts the same time.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 8'h00;
            en_q  <= 8'h01;
        end else begin
            seg_q <= seg_nxt;
            en_q  <= en_nxt;
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.digit_en = en_q;
    assign bus.pending  = pending;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2 (32-cycle frames).
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   t = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] hex_a [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    logic [7:0] d1_exp [4] = '{8'h00, 8'h00, 8'h71, 8'h71};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Output digit_en after t edges since reset release: slot k visible for t in [4k+1, 4k+4].
    function automatic logic [7:0] exp_en(input int tt);
        if (tt == 0)
            return 8'h01;
        return 8'h01 << (((tt - 1) / 4) % 8);
    endfunction

    task automatic tick();
        @(negedge clk);
        t++;
        chk("digit_en", {24'h0, bus.digit_en}, {24'h0, exp_en(t)});
    endtask

    task automatic goto(input int target);
        while (t < target)
            tick();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] bl, input logic [7:0] bk);
        bus.load       = 1'b1;
        bus.load_data  = d;
        bus.load_blank = bl;
        bus.load_blink = bk;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.load_data  = 32'h0;
        bus.load_blank = 8'h00;
        bus.load_blink = 8'h00;

        // Reset values and blank rotation
        repeat (3) @(negedge clk);
        chk("rst_digit_en", {24'h0, bus.digit_en}, 32'h01);
        chk("rst_seg_out", {24'h0, bus.seg_out}, 32'h00);
        chk("rst_pending", {31'h0, bus.pending}, 32'h0);
        reset = 1'b0;
        t = 0;
        chk("rel_digit_en", {24'h0, bus.digit_en}, 32'h01);
        chk("rel_seg_out", {24'h0, bus.seg_out}, 32'h00);
        for (int i = 0; i < 33; i++) begin
            tick();
            chk("blank_seg", {24'h0, bus.seg_out}, 32'h00);
        end

        // Basic load mid-frame, committed at t=64
        goto(40);
        do_load(32'h76543210, 8'h00, 8'h00);
        chk("load_pending_rise", {31'h0, bus.pending}, 32'h1);
        goto(62);
        chk("precommit_seg", {24'h0, bus.seg_out}, 32'h00);
        goto(63);
        chk("pending_before_commit", {31'h0, bus.pending}, 32'h1);
        goto(64);
        chk("pending_after_commit", {31'h0, bus.pending}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            goto(64 + 4 * i + 2);
            chk("basic_seg", {24'h0, bus.seg_out}, {24'h0, hex_a[i]});
        end

        // No tearing: load during digit 3 of frame 3
        goto(109);
        do_load(32'h88888888, 8'h00, 8'h00);
        for (int i = 4; i < 8; i++) begin
            goto(96 + 4 * i + 2);
            chk("notear_old_seg", {24'h0, bus.seg_out}, {24'h0, hex_a[i]});
        end
        for (int i = 0; i < 8; i++) begin
            goto(128 + 4 * i + 2);
            chk("notear_new_seg", {24'h0, bus.seg_out}, 32'h7F);
        end

        // Blank and blink: commits at t=192; blink phase is 1 in frames 6,7 and 0 in 8,9
        goto(170);
        do_load(32'hFFFFFFFF, 8'h01, 8'h02);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                goto(192 + 32 * k + 4 * i + 2);
                if (i == 0)
                    chk("blank_d0", {24'h0, bus.seg_out}, 32'h00);
                else if (i == 1)
                    chk("blink_d1", {24'h0, bus.seg_out}, {24'h0, d1_exp[k]});
                else
                    chk("blink_other", {24'h0, bus.seg_out}, 32'h71);
            end
        end

        // Back-to-back A,B then C on the boundary cycle t=351
        goto(340);
        do_load(32'h11111111, 8'h00, 8'h00);
        do_load(32'h22222222, 8'h00, 8'h00);
        goto(351);
        do_load(32'h33333333, 8'h00, 8'h00);
        chk("collide_pending", {31'h0, bus.pending}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            goto(352 + 4 * i + 2);
            chk("b_seg", {24'h0, bus.seg_out}, 32'h5B);
        end
        goto(384);
        chk("c_pending_clear", {31'h0, bus.pending}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            goto(384 + 4 * i + 2);
            chk("c_seg", {24'h0, bus.seg_out}, 32'h4F);
        end

        // Reset while a load is pending, during digit 5
        goto(403);
        do_load(32'h99999999, 8'h00, 8'h00);
        chk("d_pending", {31'h0, bus.pending}, 32'h1);
        goto(405);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_digit_en", {24'h0, bus.digit_en}, 32'h01);
        chk("midrst_seg_out", {24'h0, bus.seg_out}, 32'h00);
        chk("midrst_pending", {31'h0, bus.pending}, 32'h0);
        reset = 1'b0;
        t = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            chk("postrst_seg", {24'h0, bus.seg_out}, 32'h00);
        end
        chk("postrst_pending", {31'h0, bus.pending}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
